// File: rtl/heichips25_obs_capture.sv
// rtl/heichips25_obs_capture.sv - snapshot two projects' output bundles into a FIFO
// and stream each 25-bit word MSB-first over a valid/ready serial link.
module heichips25_obs_capture #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       trig,
  input  logic       sel,
  input  logic [7:0] uo_out_p0,
  input  logic [7:0] uio_out_p0,
  input  logic [7:0] uio_oe_p0,
  input  logic [7:0] uo_out_p1,
  input  logic [7:0] uio_out_p1,
  input  logic [7:0] uio_oe_p1,
  input  logic       ser_ready,
  output logic       ser_data,
  output logic       ser_valid,
  output logic       ser_frame,
  output logic       full,
  output logic       empty,
  output logic [7:0] drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW + 1)'(DEPTH);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  logic [24:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  state_t        state;
  logic [24:0]   shreg;
  logic [4:0]    bitcnt;

  logic [24:0] capture_word;
  logic        handshake;
  logic        pop;
  logic        push;
  logic        refuse;

  assign capture_word = sel ? {1'b1, uio_oe_p1, uio_out_p1, uo_out_p1}
                            : {1'b0, uio_oe_p0, uio_out_p0, uo_out_p0};

  assign full  = (count == CNT_FULL);
  assign empty = (count == '0);

  assign handshake = ena && (state == SHIFT) && ser_ready;
  // The shifter takes the head either from idle or on the last-bit handshake,
  // which is what keeps back-to-back words gapless.
  assign pop    = ena && !empty && ((state == IDLE) || (handshake && bitcnt == 5'd0));
  assign push   = ena && trig && (!full || pop);
  assign refuse = ena && trig && full && !pop;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= capture_word;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push) begin
        count <= count - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt <= '0;
    end else if (refuse && drop_cnt != 8'hFF) begin
      drop_cnt <= drop_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      shreg  <= '0;
      bitcnt <= '0;
    end else if (ena) begin
      case (state)
        IDLE: begin
          if (!empty) begin
            shreg  <= mem[rd_ptr];
            bitcnt <= 5'd24;
            state  <= SHIFT;
          end
        end
        SHIFT: begin
          if (ser_ready) begin
            if (bitcnt != 5'd0) begin
              shreg  <= {shreg[23:0], 1'b0};
              bitcnt <= bitcnt - 5'd1;
            end else if (!empty) begin
              shreg  <= mem[rd_ptr];
              bitcnt <= 5'd24;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Serial outputs are forced low while disabled; the underlying state is untouched.
  assign ser_valid = ena && (state == SHIFT);
  assign ser_data  = ser_valid && shreg[24];
  assign ser_frame = ser_valid && (bitcnt == 5'd24);

endmodule

// File: tb/tb_heichips25_obs_capture.sv
// tb/tb_heichips25_obs_capture.sv - directed self-checking bench for heichips25_obs_capture
module tb_heichips25_obs_capture;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic       trig;
  logic       sel;
  logic [7:0] uo_out_p0, uio_out_p0, uio_oe_p0;
  logic [7:0] uo_out_p1, uio_out_p1, uio_oe_p1;
  logic       ser_ready;
  logic       ser_data;
  logic       ser_valid;
  logic       ser_frame;
  logic       full;
  logic       empty;
  logic [7:0] drop_cnt;

  int n_cmp = 0;
  int n_err = 0;

  heichips25_obs_capture #(.DEPTH(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .trig       (trig),
    .sel        (sel),
    .uo_out_p0  (uo_out_p0),
    .uio_out_p0 (uio_out_p0),
    .uio_oe_p0  (uio_oe_p0),
    .uo_out_p1  (uo_out_p1),
    .uio_out_p1 (uio_out_p1),
    .uio_oe_p1  (uio_oe_p1),
    .ser_ready  (ser_ready),
    .ser_data   (ser_data),
    .ser_valid  (ser_valid),
    .ser_frame  (ser_frame),
    .full       (full),
    .empty      (empty),
    .drop_cnt   (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [74:0] obs, input logic [74:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    ena = 1'b1;
    trig = 1'b0;
    sel = 1'b0;
    ser_ready = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic set_p0(input logic [7:0] uo, input logic [7:0] uio, input logic [7:0] oe);
    uo_out_p0 = uo;
    uio_out_p0 = uio;
    uio_oe_p0 = oe;
  endtask

  task automatic set_p1(input logic [7:0] uo, input logic [7:0] uio, input logic [7:0] oe);
    uo_out_p1 = uo;
    uio_out_p1 = uio;
    uio_oe_p1 = oe;
  endtask

  // Collects accepted bits; frame is expected on every 25th bit counted from offset.
  task automatic recv_bits(input int nbits, input int offset, input bit toggle,
                           output logic [74:0] bits, output int got,
                           output int frame_bad, output int unstable, output int cycles);
    bit   hold;
    logic pd, pf;
    got = 0;
    bits = '0;
    frame_bad = 0;
    unstable = 0;
    cycles = 0;
    hold = 1'b0;
    pd = 1'b0;
    pf = 1'b0;
    while (got < nbits && cycles < 400) begin
      if (hold && !(ser_valid === 1'b1 && ser_data === pd && ser_frame === pf)) unstable++;
      hold = 1'b0;
      if (ser_valid === 1'b1) begin
        if (ser_ready) begin
          if (ser_frame !== (((got + offset) % 25) == 0)) frame_bad++;
          bits = {bits[73:0], ser_data};
          got++;
        end else begin
          hold = 1'b1;
          pd = ser_data;
          pf = ser_frame;
        end
      end
      tick();
      cycles++;
      if (toggle) ser_ready = ~ser_ready;
    end
  endtask

  logic [74:0] bits, bits2;
  int got, frame_bad, unstable, cycles, vcount;

  initial begin
    rst_n = 1'b0;
    ena = 1'b1;
    trig = 1'b0;
    sel = 1'b0;
    ser_ready = 1'b0;
    set_p0(8'h00, 8'h00, 8'h00);
    set_p1(8'h00, 8'h00, 8'h00);
    #1;
    chk("rst_async_valid", 75'(ser_valid), 75'd0);
    chk("rst_async_empty", 75'(empty), 75'd1);
    do_reset();
    chk("rst_data", 75'(ser_data), 75'd0);
    chk("rst_frame", 75'(ser_frame), 75'd0);
    chk("rst_full", 75'(full), 75'd0);
    chk("rst_drop", 75'(drop_cnt), 75'd0);

    // Single capture with 2-cycle latency
    ser_ready = 1'b1;
    set_p0(8'hA5, 8'h3C, 8'hFF);
    sel = 1'b0;
    trig = 1'b1;
    tick();
    trig = 1'b0;
    set_p0(8'h00, 8'h00, 8'h00);
    chk("lat_empty_after_e0", 75'(empty), 75'd0);
    chk("lat_valid_after_e0", 75'(ser_valid), 75'd0);
    tick();
    chk("lat_valid_after_e1", 75'(ser_valid), 75'd1);
    chk("lat_frame_after_e1", 75'(ser_frame), 75'd1);
    recv_bits(25, 0, 1'b0, bits, got, frame_bad, unstable, cycles);
    chk("single_word", bits, 75'(25'h0FF3CA5));
    chk("single_frame", 75'(frame_bad), 75'd0);
    chk("single_cycles", 75'(cycles), 75'd25);
    chk("single_valid_end", 75'(ser_valid), 75'd0);
    chk("single_empty_end", 75'(empty), 75'd1);

    // Project select
    set_p1(8'h01, 8'h80, 8'h00);
    sel = 1'b1;
    trig = 1'b1;
    tick();
    trig = 1'b0;
    sel = 1'b0;
    recv_bits(25, 0, 1'b0, bits, got, frame_bad, unstable, cycles);
    chk("sel1_word", bits, 75'(25'h1008001));
    chk("sel1_frame", 75'(frame_bad), 75'd0);

    // Overflow and saturation
    do_reset();
    set_p0(8'hA5, 8'h3C, 8'hFF);
    trig = 1'b1;
    repeat (6) tick();
    chk("ovf_full", 75'(full), 75'd1);
    chk("ovf_drop1", 75'(drop_cnt), 75'd1);
    chk("ovf_valid", 75'(ser_valid), 75'd1);
    trig = 1'b0;
    ser_ready = 1'b1;
    recv_bits(24, 0, 1'b0, bits, got, frame_bad, unstable, cycles);
    chk("ovf_first24", bits, 75'(25'h0FF3CA5 >> 1));
    trig = 1'b1;
    tick();
    chk("ovf_push_with_pop_drop", 75'(drop_cnt), 75'd1);
    chk("ovf_push_with_pop_full", 75'(full), 75'd1);
    chk("ovf_next_frame", 75'(ser_frame), 75'd1);
    ser_ready = 1'b0;
    repeat (300) tick();
    trig = 1'b0;
    chk("ovf_drop_sat", 75'(drop_cnt), 75'd255);
    chk("ovf_full_sat", 75'(full), 75'd1);

    // Back-to-back with toggling backpressure
    do_reset();
    set_p0(8'h11, 8'h22, 8'h33);
    sel = 1'b0;
    trig = 1'b1;
    tick();
    set_p1(8'h44, 8'h55, 8'h66);
    sel = 1'b1;
    tick();
    set_p0(8'h77, 8'h88, 8'h99);
    sel = 1'b0;
    tick();
    trig = 1'b0;
    set_p0(8'h00, 8'h00, 8'h00);
    set_p1(8'h00, 8'h00, 8'h00);
    ser_ready = 1'b1;
    recv_bits(75, 0, 1'b1, bits, got, frame_bad, unstable, cycles);
    chk("b2b_bits", bits, {25'h0332211, 25'h1665544, 25'h0998877});
    chk("b2b_frame", 75'(frame_bad), 75'd0);
    chk("b2b_stable", 75'(unstable), 75'd0);
    chk("b2b_cycles_nogap", 75'(cycles), 75'd149);
    chk("b2b_valid_end", 75'(ser_valid), 75'd0);
    chk("b2b_empty_end", 75'(empty), 75'd1);

    // ena gating mid-word
    do_reset();
    ser_ready = 1'b1;
    set_p0(8'hA5, 8'h3C, 8'hFF);
    trig = 1'b1;
    tick();
    trig = 1'b0;
    recv_bits(11, 0, 1'b0, bits, got, frame_bad, unstable, cycles);
    ena = 1'b0;
    trig = 1'b1;
    #1;
    chk("ena_off_valid", 75'(ser_valid), 75'd0);
    chk("ena_off_data", 75'(ser_data), 75'd0);
    chk("ena_off_frame", 75'(ser_frame), 75'd0);
    repeat (10) tick();
    chk("ena_off_empty", 75'(empty), 75'd1);
    chk("ena_off_drop", 75'(drop_cnt), 75'd0);
    chk("ena_off_valid_end", 75'(ser_valid), 75'd0);
    trig = 1'b0;
    ena = 1'b1;
    #1;
    recv_bits(14, 11, 1'b0, bits2, got, frame_bad, unstable, cycles);
    chk("ena_resume_word", {bits[10:0], bits2[13:0]}, 75'(25'h0FF3CA5));
    chk("ena_resume_frame", 75'(frame_bad), 75'd0);
    chk("ena_resume_valid_end", 75'(ser_valid), 75'd0);

    // Reset mid-word
    do_reset();
    set_p0(8'h5A, 8'hC3, 8'h0F);
    trig = 1'b1;
    repeat (3) tick();
    trig = 1'b0;
    ser_ready = 1'b1;
    recv_bits(11, 0, 1'b0, bits, got, frame_bad, unstable, cycles);
    chk("rmw_first11", bits, 75'(25'h00FC35A >> 14));
    rst_n = 1'b0;
    #1;
    chk("rmw_valid", 75'(ser_valid), 75'd0);
    chk("rmw_data", 75'(ser_data), 75'd0);
    chk("rmw_frame", 75'(ser_frame), 75'd0);
    chk("rmw_empty", 75'(empty), 75'd1);
    chk("rmw_full", 75'(full), 75'd0);
    tick();
    tick();
    rst_n = 1'b1;
    vcount = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (ser_valid === 1'b1) vcount++;
    end
    chk("rmw_no_residual", 75'(vcount), 75'd0);
    chk("rmw_empty_after", 75'(empty), 75'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
